status_reg: RTL and testbench
=============================

Name: status_reg

Overview:
- 6502 processor status register (P) for the NES CPU core.
- Sits directly downstream of the ALU: captures its N/Z/C/V outputs under per-flag write enables.
- Also takes flag loads from the stack (PLP/RTI), explicit set/clear ops (CLC/SEC/CLI/SEI/CLV/CLD/SED), BIT-instruction N/V capture and interrupt-entry I setting.
- Provides the carry-in back to the ALU, the pushed P byte for PHP/BRK/IRQ/NMI, and the IRQ mask used by the interrupt poller.

Parameters:
- RST_P, 8'h24, value of P read back after reset (I=1, bit5=1, all others 0). Bit 4 and bit 5 of this value are ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- ce  in  1  CPU cycle enable; all state updates are qualified by ce
- alu_n  in  1  ALU negative output
- alu_z  in  1  ALU zero output
- alu_c  in  1  ALU carry output
- alu_v  in  1  ALU overflow output
- flag_we  in  4  per-flag write enable from ALU, ordered {N,V,Z,C}
- bit_mode  in  1  BIT instruction: N<=mem_data[7], V<=mem_data[6], Z from alu_z
- mem_data  in  8  memory operand, used by bit_mode
- load_en  in  1  load P from load_data (PLP/RTI)
- load_data  in  8  byte pulled from stack
- flag_op  in  3  0 none, 1 CLC, 2 SEC, 3 CLI, 4 SEI, 5 CLV, 6 CLD, 7 SED
- set_i  in  1  interrupt-sequence I set
- instr_end  in  1  last cycle of current instruction
- brk_push  in  1  B bit value for p_push (1 for PHP/BRK, 0 for IRQ/NMI)
- p_out  out  8  current P: {N,V,1,1,D,I,Z,C} (bit4 reads 1 for debug visibility)
- p_push  out  8  {N,V,1,brk_push,D,I,Z,C}
- carry  out  1  C flag, to ALU ci
- irq_mask  out  1  I value seen by the IRQ poller

Behaviour:
- Storage: six flops, N V D I Z C. Bits 5/4 are not stored.
- Reset (async): N,V,D,I,Z,C take RST_P bits 7,6,3,2,1,0. Default: I=1, others 0.
  - p_out=8'h34, p_push=8'h24|(brk_push<<4), carry=0, irq_mask=1.
- All updates occur on a clk rising edge with ce=1; ce=0 holds all state.
- Per-flag priority, highest first:
  1. load_en: all six flags from load_data; bits 5/4 are discarded.
  2. flag_op targeting that flag.
  3. set_i (I only): I<=1.
  4. bit_mode for N/V, or flag_we bit: ALU value.
  5. Otherwise hold.
- flag_op and flag_we on different flags in the same cycle: both apply.
- bit_mode=1 overrides alu_n/alu_v with mem_data[7:6] but still needs flag_we[3]/[2] set. Z uses alu_z under flag_we[1].
- Outputs are combinational from the flops; zero-latency read, one-cycle write latency.
- carry reflects the C flop: an ALU op in cycle t sees C as written at the end of cycle t-1.
- Reset asserted mid-instruction: immediate return to reset values; no partial update survives.

Optional Feature:
- Macro: STATUS_IRQ_DELAY_EN
- Defined:
  - irq_mask is a separate flop, reset 1.
  - On ce && instr_end, irq_mask <= I value before this edge's update.
  - Effect: CLI/SEI/PLP changes reach the poller one instruction late (2A03 behaviour). RTI restores P before its last cycle, so its effect is immediate at its instr_end.
- Undefined: irq_mask is combinationally equal to I; instr_end is unused.

Test Plan:
- Reset release, no ops → p_out=8'h34, carry=0, irq_mask=1.
- Inputs flag_we=4'b1111, alu_n=1, alu_v=1, alu_z=0, alu_c=1, one ce cycle → p_out=8'hF5, carry=1.
- Inputs load_en=1, load_data=8'h00, with flag_op=SEC and flag_we=4'b1111 in the same cycle → p_out=8'h30 (load wins).
- Inputs bit_mode=1, mem_data=8'hC0, flag_we=4'b1110, alu_z=1 → N=1, V=1, Z=1, C unchanged.
- Inputs brk_push=1 with P=8'h34 → p_push=8'h34. brk_push=0 → p_push=8'h24.
- With STATUS_IRQ_DELAY_EN: CLI cycle with instr_end=1 → irq_mask stays 1. At next instr_end → irq_mask=0.
- Without STATUS_IRQ_DELAY_EN: irq_mask=0 in the cycle after CLI.
- Async reset pulse mid-cycle with ce=0 → p_out=8'h34 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/status_reg.sv
// 6502 processor status register (P): six flag flops with load/set/clear/ALU update paths.
// Optional STATUS_IRQ_DELAY_EN delays the poller's view of I by one instruction.
module status_reg #(
  parameter logic [7:0] RST_P = 8'h24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic [3:0] flag_we,
  input  logic       bit_mode,
  input  logic [7:0] mem_data,
  input  logic       load_en,
  input  logic [7:0] load_data,
  input  logic [2:0] flag_op,
  input  logic       set_i,
  input  logic       instr_end,
  input  logic       brk_push,
  output logic [7:0] p_out,
  output logic [7:0] p_push,
  output logic       carry,
  output logic       irq_mask
);

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_CLC  = 3'd1,
    OP_SEC  = 3'd2,
    OP_CLI  = 3'd3,
    OP_SEI  = 3'd4,
    OP_CLV  = 3'd5,
    OP_CLD  = 3'd6,
    OP_SED  = 3'd7
  } flag_op_e;

  flag_op_e op;
  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;

  assign op = flag_op_e'(flag_op);

  // Later assignments override earlier ones, giving load > flag_op > set_i > ALU/BIT.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (load_en) begin
      n_d = load_data[7];
      v_d = load_data[6];
      d_d = load_data[3];
      i_d = load_data[2];
      z_d = load_data[1];
      c_d = load_data[0];
    end else begin
      if (flag_we[3]) n_d = bit_mode ? mem_data[7] : alu_n;
      if (flag_we[2]) v_d = bit_mode ? mem_data[6] : alu_v;
      if (flag_we[1]) z_d = alu_z;
      if (flag_we[0]) c_d = alu_c;
      if (set_i)      i_d = 1'b1;
      case (op)
        OP_CLC:  c_d = 1'b0;
        OP_SEC:  c_d = 1'b1;
        OP_CLI:  i_d = 1'b0;
        OP_SEI:  i_d = 1'b1;
        OP_CLV:  v_d = 1'b0;
        OP_CLD:  d_d = 1'b0;
        OP_SED:  d_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q <= RST_P[7];
      v_q <= RST_P[6];
      d_q <= RST_P[3];
      i_q <= RST_P[2];
      z_q <= RST_P[1];
      c_q <= RST_P[0];
    end else if (ce) begin
      n_q <= n_d;
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
    end
  end

  assign p_out  = {n_q, v_q, 1'b1, 1'b1, d_q, i_q, z_q, c_q};
  assign p_push = {n_q, v_q, 1'b1, brk_push, d_q, i_q, z_q, c_q};
  assign carry  = c_q;

`ifdef STATUS_IRQ_DELAY_EN
  logic irq_q;

  // Poller samples the pre-update I at each instruction boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b1;
    end else if (ce && instr_end) begin
      irq_q <= i_q;
    end
  end

  assign irq_mask = irq_q;
`else
  logic unused_instr_end;

  assign unused_instr_end = instr_end;
  assign irq_mask         = i_q;
`endif

endmodule

// File: tb/tb_status_reg.sv
// Scoreboard bench for status_reg: directed vectors push expected state, a negedge monitor checks it.
module tb_status_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       alu_n, alu_z, alu_c, alu_v;
  logic [3:0] flag_we;
  logic       bit_mode;
  logic [7:0] mem_data;
  logic       load_en;
  logic [7:0] load_data;
  logic [2:0] flag_op;
  logic       set_i;
  logic       instr_end;
  logic       brk_push;
  logic [7:0] p_out;
  logic [7:0] p_push;
  logic       carry;
  logic       irq_mask;

  typedef struct {
    string      name;
    logic [7:0] p_out;
    logic [7:0] p_push;
    logic       carry;
    logic       irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  status_reg dut (
    .clk(clk), .rst(rst), .ce(ce),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .flag_we(flag_we), .bit_mode(bit_mode), .mem_data(mem_data),
    .load_en(load_en), .load_data(load_data), .flag_op(flag_op),
    .set_i(set_i), .instr_end(instr_end), .brk_push(brk_push),
    .p_out(p_out), .p_push(p_push), .carry(carry), .irq_mask(irq_mask)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: outputs are presented every cycle, so drain all pending expectations at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check8({e.name, ".p_out"},    p_out,             e.p_out);
        check8({e.name, ".p_push"},   p_push,            e.p_push);
        check8({e.name, ".carry"},    8'(carry),         8'(e.carry));
        check8({e.name, ".irq_mask"}, 8'(irq_mask),      8'(e.irq));
      end
    end
  end

  task automatic clr();
    ce = 1'b1; alu_n = 1'b0; alu_z = 1'b0; alu_c = 1'b0; alu_v = 1'b0;
    flag_we = 4'b0000; bit_mode = 1'b0; mem_data = 8'h00;
    load_en = 1'b0; load_data = 8'h00; flag_op = 3'd0;
    set_i = 1'b0; instr_end = 1'b0; brk_push = 1'b0;
  endtask

  task automatic expect_now(input string name, input logic [7:0] ep,
                            input logic irq_nd, input logic irq_dl);
    exp_t e;
    e.name   = name;
    e.p_out  = ep;
    e.p_push = {ep[7:5], brk_push, ep[3:0]};
    e.carry  = ep[0];
`ifdef STATUS_IRQ_DELAY_EN
    e.irq    = irq_dl;
`else
    e.irq    = irq_nd;
`endif
    exp_q.push_back(e);
  endtask

  // Apply the currently driven inputs for one edge, then queue the expected result.
  task automatic step(input string name, input logic [7:0] ep,
                      input logic irq_nd, input logic irq_dl);
    @(posedge clk);
    #1;
    expect_now(name, ep, irq_nd, irq_dl);
    @(negedge clk);
    #1;
    clr();
  endtask

  initial begin
    clr();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    step("reset_idle", 8'h34, 1'b1, 1'b1);
    brk_push = 1'b1;
    step("brk_push1", 8'h34, 1'b1, 1'b1);
    flag_we = 4'b1111; alu_n = 1'b1; alu_v = 1'b1; alu_z = 1'b0; alu_c = 1'b1;
    step("alu_all", 8'hF5, 1'b1, 1'b1);
    load_en = 1'b1; load_data = 8'h00; flag_op = 3'd2; flag_we = 4'b1111;
    alu_n = 1'b1; alu_v = 1'b1; alu_z = 1'b1; alu_c = 1'b1;
    step("load_wins", 8'h30, 1'b0, 1'b1);
    bit_mode = 1'b1; mem_data = 8'hC0; flag_we = 4'b1110; alu_z = 1'b1;
    step("bit_mode", 8'hF2, 1'b0, 1'b1);
    flag_op = 3'd2; flag_we = 4'b1110;
    step("sec_plus_alu", 8'h31, 1'b0, 1'b1);
    flag_op = 3'd1; flag_we = 4'b0001; alu_c = 1'b1;
    step("clc_over_alu", 8'h30, 1'b0, 1'b1);
    flag_op = 3'd7;
    step("sed", 8'h38, 1'b0, 1'b1);
    flag_op = 3'd6;
    step("cld", 8'h30, 1'b0, 1'b1);
    flag_op = 3'd4;
    step("sei", 8'h34, 1'b1, 1'b1);
    flag_op = 3'd3; instr_end = 1'b1;
    step("cli_end", 8'h30, 1'b0, 1'b1);
    instr_end = 1'b1;
    step("next_end", 8'h30, 1'b0, 1'b0);
    set_i = 1'b1;
    step("set_i", 8'h34, 1'b1, 1'b0);
    set_i = 1'b1; flag_op = 3'd3;
    step("cli_over_set_i", 8'h30, 1'b0, 1'b0);
    flag_we = 4'b0100; alu_v = 1'b1;
    step("alu_v", 8'h70, 1'b0, 1'b0);
    flag_op = 3'd5; flag_we = 4'b0100; alu_v = 1'b1;
    step("clv_over_alu", 8'h30, 1'b0, 1'b0);
    ce = 1'b0; load_en = 1'b1; load_data = 8'hFF; flag_we = 4'b1111;
    alu_n = 1'b1; alu_v = 1'b1; alu_z = 1'b1; alu_c = 1'b1; instr_end = 1'b1;
    step("ce_hold", 8'h30, 1'b0, 1'b0);
    load_en = 1'b1; load_data = 8'hFF;
    step("load_ff", 8'hFF, 1'b1, 1'b0);
    load_en = 1'b1; load_data = 8'hCB; instr_end = 1'b1;
    step("load_cb", 8'hFB, 1'b0, 1'b1);

    // Asynchronous reset between edges, checked before any further rising edge.
    @(posedge clk);
    #2;
    ce = 1'b0;
    rst = 1'b1;
    #1;
    expect_now("async_rst", 8'h34, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    rst = 1'b0;
    clr();
    step("post_rst_idle", 8'h34, 1'b1, 1'b1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
